// File: rtl/lb_reg_bank_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : lb_reg_bank_pkg
// Purpose : Shared constants and types for the local-bus register bank:
//           fixed register offsets inside the window, the data returned for
//           in-window unmapped reads, the read-pipeline depth limit and the
//           address-decode region type.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package lb_reg_bank_pkg;

    // Byte offsets of the fixed registers inside the window
    localparam logic [31:0] OFS_ID    = 32'h0000_0000;
    localparam logic [31:0] OFS_PULSE = 32'h0000_0004;
    localparam logic [31:0] OFS_TS_LO = 32'h0000_0008;
    localparam logic [31:0] OFS_TS_HI = 32'h0000_000C;
    localparam logic [31:0] OFS_RW0   = 32'h0000_0010;

    // Returned for reads that hit the window but no register
    localparam logic [31:0] LB_MISS_DATA = 32'hDEAD_BEEF;

    // Maximum read latency in clk_lb cycles
    localparam int LB_RD_MAX_DEPTH = 4;

    // Address decode result
    typedef enum logic [2:0] {
        REG_NONE  = 3'd0,   // outside the window
        REG_ID    = 3'd1,
        REG_PULSE = 3'd2,
        REG_TS_LO = 3'd3,
        REG_TS_HI = 3'd4,
        REG_RW    = 3'd5,
        REG_RO    = 3'd6,
        REG_MISS  = 3'd7    // inside the window, no register
    } lb_region_e;

endpackage
`default_nettype wire

// File: rtl/lb_reg_bank_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : lb_reg_bank_if
// Purpose : 32-bit local-bus signal bundle between the bus master
//           (ft232_xface side) and one or more register banks.
// Ports   : lb_wr     write strobe (1 cycle)
//           lb_rd     read strobe (1 cycle)
//           lb_addr   byte address, bits [1:0] ignored
//           lb_wr_d   write data
//           lb_rd_d   read data, zero when not valid
//           lb_rd_rdy read-data-valid pulse
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
interface lb_reg_bank_if;

    logic        lb_wr;
    logic        lb_rd;
    logic [31:0] lb_addr;
    logic [31:0] lb_wr_d;
    logic [31:0] lb_rd_d;
    logic        lb_rd_rdy;

    modport master (
        output lb_wr, lb_rd, lb_addr, lb_wr_d,
        input  lb_rd_d, lb_rd_rdy
    );

    modport slave (
        input  lb_wr, lb_rd, lb_addr, lb_wr_d,
        output lb_rd_d, lb_rd_rdy
    );

endinterface
`default_nettype wire

// File: rtl/lb_rd_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : lb_rd_pipe
// Purpose : Fixed-length delay line for the read response {rdy, data}.
//           STAGES = 0 is a pure pass-through. Every stage resets to zero so
//           reads in flight at reset are dropped.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           i_rdy, i_data   response entering the line
//           o_rdy, o_data   response leaving the line
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module lb_rd_pipe
    import lb_reg_bank_pkg::*;
#(
    parameter int STAGES = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_rdy,
    input  wire logic [31:0] i_data,
    output logic             o_rdy,
    output logic [31:0]      o_data
);

    // Depth is limited to what the total read latency may add
    localparam int c_DEPTH = (STAGES < 0) ? 0 :
                             (STAGES > LB_RD_MAX_DEPTH - 1) ? LB_RD_MAX_DEPTH - 1 : STAGES;

    generate
        if (c_DEPTH == 0) begin : g_bypass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;
            assign o_rdy  = i_rdy;
            assign o_data = i_data;
        end else begin : g_stages
            logic [c_DEPTH-1:0] r_rdy_q;
            logic [c_DEPTH-1:0] w_rdy_d;
            logic [31:0]        r_data_q [c_DEPTH];
            logic [31:0]        w_data_d [c_DEPTH];

            always_comb begin
                w_rdy_d     = r_rdy_q;
                w_data_d    = r_data_q;
                w_rdy_d[0]  = i_rdy;
                w_data_d[0] = i_data;
                for (int i = 1; i < c_DEPTH; i++) begin
                    w_rdy_d[i]  = r_rdy_q[i-1];
                    w_data_d[i] = r_data_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rdy_q <= '0;
                    for (int i = 0; i < c_DEPTH; i++) begin
                        r_data_q[i] <= '0;
                    end
                end else begin
                    r_rdy_q  <= w_rdy_d;
                    r_data_q <= w_data_d;
                end
            end

            assign o_rdy  = r_rdy_q[c_DEPTH-1];
            assign o_data = r_data_q[c_DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lb_reg_bank.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : lb_reg_bank
// Purpose : Parametrised local-bus register bank. Decodes an aligned window
//           and provides an ID word, a self-clearing pulse register, NUM_RW
//           read/write registers, NUM_RO status inputs and (optionally) a
//           coherent 64-bit timestamp. Out-of-window cycles leave lb_rd_d at
//           zero so several banks can be OR-combined on one bus.
// Config  : define LB_REG_BANK_TIMESTAMP_EN to build the 64-bit timestamp at
//           TS_LO/TS_HI; otherwise those offsets read as unmapped.
// Ports   : clk_lb     local-bus clock
//           reset      asynchronous active-high reset
//           lb         local-bus slave modport
//           rw_out     RW register contents, reg i at [32i+31:32i]
//           ro_in      status inputs, same packing, sampled in the lb_rd cycle
//           pulse_out  one-cycle pulse word from writes to PULSE
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module lb_reg_bank
    import lb_reg_bank_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_SPAN  = 256,
    parameter int          NUM_RW     = 4,
    parameter int          NUM_RO     = 2,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] ID_VALUE   = 32'h1234_5678,
    parameter logic [31:0] RW_RESET   = 32'h0000_0000
) (
    input  wire logic                                   clk_lb,
    input  wire logic                                   reset,
    lb_reg_bank_if.slave                                lb,
    output logic [32*NUM_RW-1:0]                        rw_out,
    input  wire logic [32*((NUM_RO > 0) ? NUM_RO : 1)-1:0] ro_in,
    output logic [31:0]                                 pulse_out
);

    localparam int c_ADDR_W = $clog2(ADDR_SPAN);

    logic        w_hit;
    logic [31:0] w_ofs;
    lb_region_e  w_region;
    logic [31:0] w_rd_mux;
    logic        w_unused_addr_lsbs;

    logic [31:0] r_rw_q [NUM_RW];
    logic [31:0] w_rw_d [NUM_RW];
    logic [31:0] r_pulse_q;
    logic [31:0] w_pulse_d;
    logic        r_rd_rdy_q;
    logic        w_rd_rdy_d;
    logic [31:0] r_rd_data_q;
    logic [31:0] w_rd_data_d;

`ifdef LB_REG_BANK_TIMESTAMP_EN
    logic [63:0] r_ts_q;
    logic [63:0] w_ts_d;
    logic [31:0] r_ts_snap_q;
    logic [31:0] w_ts_snap_d;
`endif

    assign w_hit              = (lb.lb_addr[31:c_ADDR_W] == BASE_ADDR[31:c_ADDR_W]);
    assign w_ofs              = 32'({lb.lb_addr[c_ADDR_W-1:2], 2'b00});
    assign w_unused_addr_lsbs = ^lb.lb_addr[1:0];

    // Address decode and read-data mux; evaluated in the lb_rd cycle so the
    // read sees register state from before any same-cycle write.
    always_comb begin
        w_region = REG_NONE;
        w_rd_mux = '0;
        if (w_hit) begin
            w_region = REG_MISS;
            w_rd_mux = LB_MISS_DATA;
            if (w_ofs == OFS_ID) begin
                w_region = REG_ID;
                w_rd_mux = ID_VALUE;
            end
            if (w_ofs == OFS_PULSE) begin
                w_region = REG_PULSE;
                w_rd_mux = '0;
            end
`ifdef LB_REG_BANK_TIMESTAMP_EN
            if (w_ofs == OFS_TS_LO) begin
                w_region = REG_TS_LO;
                w_rd_mux = r_ts_q[31:0];
            end
            if (w_ofs == OFS_TS_HI) begin
                w_region = REG_TS_HI;
                w_rd_mux = r_ts_snap_q;
            end
`endif
            for (int i = 0; i < NUM_RW; i++) begin
                if (w_ofs == OFS_RW0 + 32'(4 * i)) begin
                    w_region = REG_RW;
                    w_rd_mux = r_rw_q[i];
                end
            end
            for (int j = 0; j < NUM_RO; j++) begin
                if (w_ofs == OFS_RW0 + 32'(4 * (NUM_RW + j))) begin
                    w_region = REG_RO;
                    w_rd_mux = ro_in[32*j +: 32];
                end
            end
        end
    end

    always_comb begin
        w_rw_d    = r_rw_q;
        w_pulse_d = '0;
        if (lb.lb_wr && (w_region == REG_PULSE)) begin
            w_pulse_d = lb.lb_wr_d;
        end
        for (int i = 0; i < NUM_RW; i++) begin
            if (lb.lb_wr && w_hit && (w_ofs == OFS_RW0 + 32'(4 * i))) begin
                w_rw_d[i] = lb.lb_wr_d;
            end
        end
        // First response stage; data forced to zero unless this bank answers
        w_rd_rdy_d  = lb.lb_rd & w_hit;
        w_rd_data_d = w_rd_rdy_d ? w_rd_mux : '0;
    end

    always_ff @(posedge clk_lb or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_rw_q[i] <= RW_RESET;
            end
            r_pulse_q   <= '0;
            r_rd_rdy_q  <= 1'b0;
            r_rd_data_q <= '0;
        end else begin
            r_rw_q      <= w_rw_d;
            r_pulse_q   <= w_pulse_d;
            r_rd_rdy_q  <= w_rd_rdy_d;
            r_rd_data_q <= w_rd_data_d;
        end
    end

`ifdef LB_REG_BANK_TIMESTAMP_EN
    // Reading TS_LO captures the upper half at the same instant so a
    // following TS_HI read pairs with it even across a carry.
    always_comb begin
        w_ts_d      = r_ts_q + 64'd1;
        w_ts_snap_d = r_ts_snap_q;
        if (lb.lb_rd && (w_region == REG_TS_LO)) begin
            w_ts_snap_d = r_ts_q[63:32];
        end
    end

    always_ff @(posedge clk_lb or posedge reset) begin
        if (reset) begin
            r_ts_q      <= '0;
            r_ts_snap_q <= '0;
        end else begin
            r_ts_q      <= w_ts_d;
            r_ts_snap_q <= w_ts_snap_d;
        end
    end
`endif

    always_comb begin
        rw_out = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            rw_out[32*i +: 32] = r_rw_q[i];
        end
    end

    assign pulse_out = r_pulse_q;

    lb_rd_pipe #(
        .STAGES (RD_LATENCY - 1)
    ) u_rd_pipe (
        .clk    (clk_lb),
        .rst    (reset),
        .i_rdy  (r_rd_rdy_q),
        .i_data (r_rd_data_q),
        .o_rdy  (lb.lb_rd_rdy),
        .o_data (lb.lb_rd_d)
    );

endmodule
`default_nettype wire
